// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage_pkg : shared fetch constants (NOP encoding, reset PC, FSM states)
// Revision: 1.0
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_2000;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage_if : instruction-memory request/response bus
// Revision: 1.0
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int ADDR_W = 32
);

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_resp_valid;
  logic [31:0]       imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_skid_buffer : one-entry instruction+PC holding buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_skid_buffer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [31:0]       inst_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              full,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] pc_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      inst_out <= '0;
      pc_out   <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full     <= 1'b1;
      inst_out <= inst_in;
      pc_out   <= pc_in;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage : PC, imem handshake and F/X pipeline register of the F-X-W core
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [31:0]       NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_delay,
  input  logic              noop,
  input  logic              cwe2,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_stage_if.master     imem,
  output logic [31:0]       inst_x,
  output logic [ADDR_W-1:0] pc_x,
  output logic              valid_x,
  output logic [6:0]        opcode_x,
  output logic [4:0]        rs1_x,
  output logic [4:0]        rs2_x
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] pc_f, pc_f_nxt;
  logic              stale, stale_nxt;
  logic              x_ready, resp_in_wait, redirect;
  logic              load_x, from_skid, skid_load;
  logic              skid_full;
  logic [31:0]       skid_inst, fetch_inst;
  logic [ADDR_W-1:0] skid_pc, fetch_pc;

  assign x_ready      = cwe2 & ~pc_delay;
  assign resp_in_wait = (state == ST_WAIT) & imem.imem_resp_valid;
  assign redirect     = redirect_valid & (state != ST_BOOT);
  assign from_skid    = (state == ST_HOLD) & skid_full;
  assign fetch_inst   = from_skid ? skid_inst : imem.imem_resp_data;
  assign fetch_pc     = from_skid ? skid_pc : pc_f;

  assign imem.imem_req_valid = (state == ST_REQ);
  assign imem.imem_addr      = pc_f & ALIGN_MASK;

  always_comb begin
    state_nxt = state;
    stale_nxt = stale;
    pc_f_nxt  = pc_f;
    load_x    = 1'b0;
    skid_load = 1'b0;
    case (state)
      ST_BOOT: state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem.imem_req_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem.imem_resp_valid) begin
          state_nxt = ST_REQ;
          if (stale) begin
            stale_nxt = 1'b0;
          end else if (x_ready) begin
            load_x   = 1'b1;
            pc_f_nxt = pc_f + PC_STEP;
          end else begin
            skid_load = 1'b1;
            state_nxt = ST_HOLD;
          end
        end
      end
      default: begin
        if (!skid_full) begin
          state_nxt = ST_REQ;
        end else if (x_ready) begin
          load_x    = 1'b1;
          pc_f_nxt  = pc_f + PC_STEP;
          state_nxt = ST_REQ;
        end
      end
    endcase

    // A response landing in the same cycle as the redirect is the one we were
    // waiting for, so it is simply dropped rather than marked stale.
    if (redirect) begin
      load_x    = 1'b0;
      skid_load = 1'b0;
      pc_f_nxt  = redirect_pc & ALIGN_MASK;
      case (state)
        ST_REQ:  stale_nxt = imem.imem_req_ready;
        ST_WAIT: stale_nxt = ~resp_in_wait;
        default: stale_nxt = 1'b0;
      endcase
      state_nxt = stale_nxt ? ST_WAIT : ST_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      pc_f  <= RESET_PC;
      stale <= 1'b0;
    end else begin
      state <= state_nxt;
      pc_f  <= pc_f_nxt;
      stale <= stale_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_x  <= NOP_INST;
      pc_x    <= '0;
      valid_x <= 1'b0;
    end else if (redirect) begin
      inst_x  <= NOP_INST;
      valid_x <= 1'b0;
    end else if (load_x) begin
      pc_x    <= fetch_pc;
      inst_x  <= noop ? NOP_INST : fetch_inst;
      valid_x <= ~noop;
    end
  end

  fetch_skid_buffer #(
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .drain    (load_x & from_skid),
    .clear    (redirect),
    .inst_in  (imem.imem_resp_data),
    .pc_in    (pc_f),
    .full     (skid_full),
    .inst_out (skid_inst),
    .pc_out   (skid_pc)
  );

  assign opcode_x = inst_x[6:0];
  assign rs1_x    = inst_x[19:15];
  assign rs2_x    = inst_x[24:20];

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed bench with a transaction-level fetch model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_delay, noop, cwe2, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst_x, pc_x;
  logic        valid_x;
  logic [6:0]  opcode_x;
  logic [4:0]  rs1_x, rs2_x;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(32)) imem_bus ();

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_delay       (pc_delay),
    .noop           (noop),
    .cwe2           (cwe2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .inst_x         (inst_x),
    .pc_x           (pc_x),
    .valid_x        (valid_x),
    .opcode_x       (opcode_x),
    .rs1_x          (rs1_x),
    .rs2_x          (rs2_x)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h00B3};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt  = 0;
  int          mem_lat  = 1;

  task automatic mem_drive();
    imem_bus.imem_req_ready = 1'b1;
    if (mem_pend && mem_cnt == 0) begin
      imem_bus.imem_resp_valid = 1'b1;
      imem_bus.imem_resp_data  = mem_word(mem_addr);
      mem_pend = 1'b0;
    end else begin
      imem_bus.imem_resp_valid = 1'b0;
      imem_bus.imem_resp_data  = 32'hDEAD_BEEF;
      if (mem_pend) mem_cnt--;
    end
    #1;
    if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
      mem_pend = 1'b1;
      mem_addr = imem_bus.imem_addr;
      mem_cnt  = mem_lat - 1;
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_boot, m_out, m_stale, m_held, m_valid, m_xknown;
  logic [31:0] m_pc, m_held_inst, m_inst, m_xpc;

  task automatic model_reset();
    m_boot = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0;
    m_pc = 32'h0000_2000; m_held_inst = '0;
    m_inst = NOP; m_valid = 1'b0; m_xpc = '0; m_xknown = 1'b1;
  endtask

  task automatic x_load(input logic [31:0] inst, input logic [31:0] pc);
    m_xpc = pc;
    m_xknown = 1'b1;
    m_inst  = noop ? NOP : inst;
    m_valid = !noop;
  endtask

  function automatic bit exp_req();
    return !m_boot && !m_out && !m_held;
  endfunction

  task automatic model_step();
    bit take, got, acc;
    take = cwe2 && !pc_delay;
    got  = m_out && imem_bus.imem_resp_valid;
    acc  = exp_req() && imem_bus.imem_req_ready;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc & ~32'd3;
      m_inst = NOP; m_valid = 1'b0; m_xknown = 1'b0;
      m_held = 1'b0;
      m_out = acc || (m_out && !got);
      m_stale = m_out;
    end else if (got) begin
      m_out = 1'b0;
      if (m_stale) m_stale = 1'b0;
      else if (take) begin x_load(imem_bus.imem_resp_data, m_pc); m_pc = m_pc + 32'd4; end
      else begin m_held = 1'b1; m_held_inst = imem_bus.imem_resp_data; end
    end else if (m_held && take) begin
      x_load(m_held_inst, m_pc);
      m_held = 1'b0;
      m_pc = m_pc + 32'd4;
    end else if (acc) begin
      m_out = 1'b1;
    end
  endtask

  // Single compare process: outputs are stable mid-low-phase.
  always @(negedge clk) begin
    #2;
    if (!rst_n) model_reset();
    chk("req_valid", {31'd0, imem_bus.imem_req_valid}, {31'd0, exp_req()});
    chk("imem_addr", imem_bus.imem_addr, m_pc);
    chk("inst_x", inst_x, m_inst);
    chk("valid_x", {31'd0, valid_x}, {31'd0, m_valid});
    if (m_xknown) chk("pc_x", pc_x, m_xpc);
    chk("opcode_x", {25'd0, opcode_x}, {25'd0, m_inst[6:0]});
    chk("rs1_x", {27'd0, rs1_x}, {27'd0, m_inst[19:15]});
    chk("rs2_x", {27'd0, rs2_x}, {27'd0, m_inst[24:20]});
    if (rst_n) begin
      assert (!imem_bus.imem_resp_valid || m_out)
        else $error("protocol: imem response with no request outstanding");
      model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic pd, input logic nop, input logic cw,
                     input logic rv, input logic [31:0] rpc);
    pc_delay = pd; noop = nop; cwe2 = cw; redirect_valid = rv; redirect_pc = rpc;
    mem_drive();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 50000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pc_delay = 1'b0; noop = 1'b0; cwe2 = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_bus.imem_req_ready = 1'b0;
    imem_bus.imem_resp_valid = 1'b0;
    imem_bus.imem_resp_data = '0;
    repeat (2) @(negedge clk);
    chk("lit reset inst_x", inst_x, 32'h0000_0013);
    chk("lit reset pc_x", pc_x, 32'h0);
    chk("lit reset req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);
    rst_n = 1'b1;

    // 1-cycle memory: one instruction every two cycles
    idle(1);
    chk("lit first addr", imem_bus.imem_addr, 32'h0000_2000);
    idle(2);
    chk("lit inst 2000", inst_x, 32'h2000_00B3);
    chk("lit pc_x 2000", pc_x, 32'h0000_2000);
    chk("lit next addr", imem_bus.imem_addr, 32'h0000_2004);

    // pc_delay for 3 cycles while the 2004 word returns
    idle(1);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("lit pd req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);
    chk("lit pd addr", imem_bus.imem_addr, 32'h0000_2004);
    chk("lit pd inst_x held", inst_x, 32'h2000_00B3);
    idle(1);
    chk("lit drained inst", inst_x, 32'h2004_00B3);
    chk("lit addr after drain", imem_bus.imem_addr, 32'h0000_2008);

    // cwe2=0 for 2 cycles with noop asserted: X holds, skid fills
    idle(1);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("lit cwe2 inst_x", inst_x, 32'h2004_00B3);
    chk("lit cwe2 pc_x", pc_x, 32'h0000_2004);
    chk("lit cwe2 req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd0);

    // noop on loading the 2008 word
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("lit noop inst_x", inst_x, 32'h0000_0013);
    chk("lit noop valid_x", {31'd0, valid_x}, 32'd0);
    chk("lit noop pc_x", pc_x, 32'h0000_2008);
    chk("lit noop next addr", imem_bus.imem_addr, 32'h0000_200C);

    // redirect while WAIT with a 3-cycle memory: late word is dropped
    mem_lat = 3;
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3002);
    chk("lit redir bubble", inst_x, 32'h0000_0013);
    idle(2);
    chk("lit redir addr", imem_bus.imem_addr, 32'h0000_3000);
    chk("lit redir req_valid", {31'd0, imem_bus.imem_req_valid}, 32'd1);
    idle(4);
    chk("lit inst 3000", inst_x, 32'h3000_00B3);
    mem_lat = 1;

    // redirect in REQ with ready, target wraps past the top of memory
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    idle(1);
    chk("lit wrap addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    idle(2);
    chk("lit wrap inst", inst_x, 32'hFFFC_00B3);
    chk("lit wrap next addr", imem_bus.imem_addr, 32'h0000_0000);

    // redirect in HOLD beats pc_delay and cwe2
    idle(1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    chk("lit hold redir addr", imem_bus.imem_addr, 32'h0000_0100);
    idle(2);
    chk("lit inst 0100", inst_x, 32'h0100_00B3);

    // asynchronous reset while waiting for a response
    idle(1);
    mem_pend = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("lit async inst_x", inst_x, 32'h0000_0013);
    chk("lit async valid_x", {31'd0, valid_x}, 32'd0);
    chk("lit async pc_x", pc_x, 32'h0);
    chk("lit async addr", imem_bus.imem_addr, 32'h0000_2000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("lit post-reset addr", imem_bus.imem_addr, 32'h0000_2000);
    idle(2);
    chk("lit post-reset inst", inst_x, 32'h2000_00B3);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
